// File: rtl/fnn_pkg.sv
// Shared types and helpers for the fully-connected layer plumbing.
package fnn_pkg;

    typedef enum logic {
        SER_IDLE  = 1'b0,
        SER_SHIFT = 1'b1
    } ser_state_t;

    // Index width for a vector of n words; a single-word vector still needs one bit.
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/layer_capture_bank.sv
// Per-neuron capture registers for one output vector, with a captured mask,
// a registered full flag and a sticky overrun detector.
module layer_capture_bank
    import fnn_pkg::*;
#(
    parameter int NUM_NEURONS = 30,
    parameter int DATA_WIDTH  = 16
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic [NUM_NEURONS*DATA_WIDTH-1:0] i_neuron_out,
    input  logic [NUM_NEURONS-1:0]            i_neuron_valid,
    input  logic                              i_load,
    output logic [NUM_NEURONS*DATA_WIDTH-1:0] o_bank,
    output logic                              o_full,
    output logic                              o_overrun
);

    logic [NUM_NEURONS*DATA_WIDTH-1:0] r_bank;
    logic [NUM_NEURONS-1:0]            r_captured;
    logic                              r_full;
    logic                              r_overrun;
    logic [NUM_NEURONS-1:0]            w_keep;
    logic [NUM_NEURONS-1:0]            w_take;

    // A load empties the mask on this same edge, so arriving words start the next vector.
    assign w_keep = i_load ? '0 : r_captured;
    assign w_take = i_neuron_valid & ~w_keep;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_bank     <= '0;
            r_captured <= '0;
            r_full     <= 1'b0;
            r_overrun  <= 1'b0;
        end else begin
            r_captured <= w_keep | i_neuron_valid;
            r_full     <= i_load ? 1'b0 : &r_captured;
            if (|(i_neuron_valid & w_keep)) begin
                r_overrun <= 1'b1;
            end
            for (int i = 0; i < NUM_NEURONS; i++) begin
                if (w_take[i]) begin
                    r_bank[i*DATA_WIDTH +: DATA_WIDTH] <= i_neuron_out[i*DATA_WIDTH +: DATA_WIDTH];
                end
            end
        end
    end

    assign o_bank    = r_bank;
    assign o_full    = r_full;
    assign o_overrun = r_overrun;

endmodule

// File: rtl/layer_out_serializer.sv
// Collects one layer's parallel neuron outputs and replays them, index 0 first,
// as a gap-free serial stream for the next layer. Double-buffered via the capture bank.
module layer_out_serializer
    import fnn_pkg::*;
#(
    parameter int NUM_NEURONS = 30,
    parameter int DATA_WIDTH  = 16
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic [NUM_NEURONS*DATA_WIDTH-1:0] neuron_out,
    input  logic [NUM_NEURONS-1:0]            neuron_valid,
    output logic [DATA_WIDTH-1:0]             data_out,
    output logic                              data_valid,
    output logic                              data_last,
    output logic                              busy,
    output logic                              overrun
);

    localparam int IDX_W = idx_width(NUM_NEURONS);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_NEURONS - 1);

    ser_state_t                        r_state;
    logic [DATA_WIDTH-1:0]             r_shift [NUM_NEURONS];
    logic [IDX_W-1:0]                  r_idx;
    logic [DATA_WIDTH-1:0]             r_data;
    logic                              r_valid;
    logic                              r_last;
    logic [NUM_NEURONS*DATA_WIDTH-1:0] w_bank;
    logic                              w_full;
    logic                              w_overrun;
    logic                              w_load;
    logic [IDX_W-1:0]                  w_next;

    layer_capture_bank #(
        .NUM_NEURONS(NUM_NEURONS),
        .DATA_WIDTH (DATA_WIDTH)
    ) u_bank (
        .clk           (clk),
        .rst           (rst),
        .i_neuron_out  (neuron_out),
        .i_neuron_valid(neuron_valid),
        .i_load        (w_load),
        .o_bank        (w_bank),
        .o_full        (w_full),
        .o_overrun     (w_overrun)
    );

    // Reload from IDLE, or on the final word of a stream so the next vector follows with no gap.
    assign w_load = w_full && ((r_state == SER_IDLE) || (r_idx == LAST_IDX));
    assign w_next = r_idx + 1'b1;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= SER_IDLE;
            r_idx   <= '0;
            r_data  <= '0;
            r_valid <= 1'b0;
            r_last  <= 1'b0;
            for (int i = 0; i < NUM_NEURONS; i++) begin
                r_shift[i] <= '0;
            end
        end else if (w_load) begin
            for (int i = 0; i < NUM_NEURONS; i++) begin
                r_shift[i] <= w_bank[i*DATA_WIDTH +: DATA_WIDTH];
            end
            r_state <= SER_SHIFT;
            r_idx   <= '0;
            r_data  <= w_bank[DATA_WIDTH-1:0];
            r_valid <= 1'b1;
            r_last  <= 1'b0;
        end else if (r_state == SER_SHIFT) begin
            if (r_idx == LAST_IDX) begin
                r_state <= SER_IDLE;
                r_valid <= 1'b0;
                r_last  <= 1'b0;
            end else begin
                r_idx   <= w_next;
                r_data  <= r_shift[w_next];
                r_valid <= 1'b1;
                r_last  <= (w_next == LAST_IDX);
            end
        end
    end

    assign data_out   = r_data;
    assign data_valid = r_valid;
    assign data_last  = r_last;
    assign busy       = (r_state == SER_SHIFT);
    assign overrun    = w_overrun;

endmodule

// File: tb/tb_layer_out_serializer.sv
// Randomised bench for layer_out_serializer: a vector-level reference model schedules
// each expected stream; an independent monitor checks every cycle against the queue.
module tb_layer_out_serializer;

    localparam int N = 4;
    localparam int W = 16;
    localparam int INF = 32'h3fff_ffff;

    typedef struct {
        logic [W-1:0] data;
        logic         last;
        int           cyc;
        logic [47:0]  dot;
    } exp_t;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic [N*W-1:0]   neuron_out = '0;
    logic [N-1:0]     neuron_valid = '0;
    logic [W-1:0]     data_out;
    logic             data_valid;
    logic             data_last;
    logic             busy;
    logic             overrun;

    int   cyc = 0;
    int   n_tests = 0;
    int   n_fail = 0;
    exp_t exp_q[$];

    // Reference model: vector-level bookkeeping
    logic [W-1:0] m_bank [N];
    logic [N-1:0] m_mask = '0;
    logic         m_pending = 1'b0;
    int           m_load_edge = 0;
    int           m_last_load = -1000;
    int           ovr_from = INF;
    int           vec_exp = 0;
    logic [7:0]   wt [N];

    // Monitor-side state
    logic [W-1:0] hold_data = '0;
    logic [47:0]  acc = '0;
    int           mon_k = 0;
    int           vec_seen = 0;

    layer_out_serializer #(
        .NUM_NEURONS(N),
        .DATA_WIDTH (W)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .neuron_out  (neuron_out),
        .neuron_valid(neuron_valid),
        .data_out    (data_out),
        .data_valid  (data_valid),
        .data_last   (data_last),
        .busy        (busy),
        .overrun     (overrun)
    );

    // Clock and edge counter
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] expv);
        n_tests++;
        if (act !== expv) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, expv, cyc);
        end
    endtask

    function automatic logic [N*W-1:0] pack4(input logic [W-1:0] a, b, c, d);
        return {d, c, b, a};
    endfunction

    // Apply the spec rules for one clock edge e to the model.
    task automatic model_edge(input int e, input logic [N-1:0] v, input logic [N*W-1:0] w);
        logic [47:0] dot;
        if (m_pending && e == m_load_edge) begin
            dot = '0;
            for (int k = 0; k < N; k++) dot += 48'(m_bank[k]) * 48'(wt[k]);
            for (int k = 0; k < N; k++) begin
                exp_q.push_back('{data: m_bank[k], last: (k == N-1), cyc: e + k, dot: dot});
            end
            m_last_load = e;
            m_pending = 1'b0;
            m_mask = '0;
            vec_exp++;
        end
        for (int i = 0; i < N; i++) begin
            if (v[i]) begin
                if (m_mask[i]) begin
                    if (ovr_from > e) ovr_from = e;
                end else begin
                    m_mask[i] = 1'b1;
                    m_bank[i] = w[i*W +: W];
                end
            end
        end
        if (&m_mask && !m_pending) begin
            m_pending = 1'b1;
            m_load_edge = (e + 2 > m_last_load + N) ? e + 2 : m_last_load + N;
        end
    endtask

    // Driver: one clock of stimulus
    task automatic step(input logic [N-1:0] v, input logic [N*W-1:0] w);
        @(negedge clk);
        rst = 1'b0;
        neuron_valid = v;
        neuron_out = w;
        model_edge(cyc + 1, v, w);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step('0, '0);
    endtask

    task automatic do_reset();
        int e;
        @(negedge clk);
        rst = 1'b1;
        neuron_valid = '0;
        e = cyc + 1;
        while (exp_q.size() > 0 && exp_q[$].cyc >= e) void'(exp_q.pop_back());
        if (exp_q.size() > 0 && !exp_q[$].last) begin
            // a partially presented vector is discarded: drop its remaining words
            while (exp_q.size() > 0 && exp_q[$].cyc >= e) void'(exp_q.pop_back());
        end
        if (mon_k != 0 || m_last_load + N > e) vec_exp--;
        m_mask = '0;
        m_pending = 1'b0;
        m_last_load = -1000;
        ovr_from = INF;
        hold_data = '0;
        acc = '0;
        mon_k = 0;
    endtask

    // Monitor / scoreboard
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0 && exp_q[0].cyc < cyc) begin
                check("missed_word", 64'(cyc), 64'(exp_q[0].cyc));
                void'(exp_q.pop_front());
            end
            if (exp_q.size() > 0 && exp_q[0].cyc == cyc) begin
                e = exp_q.pop_front();
                check("valid", 64'(data_valid), 64'd1);
                check("data", 64'(data_out), 64'(e.data));
                check("last", 64'(data_last), 64'(e.last));
                check("busy", 64'(busy), 64'd1);
                hold_data = e.data;
                if (mon_k < N) acc += 48'(data_out) * 48'(wt[mon_k]);
                mon_k++;
                if (e.last) begin
                    check("dot", 64'(acc), 64'(e.dot));
                    acc = '0;
                    mon_k = 0;
                    vec_seen++;
                end
            end else begin
                check("idle_valid", 64'(data_valid), 64'd0);
                check("idle_last", 64'(data_last), 64'd0);
                check("idle_busy", 64'(busy), 64'd0);
                check("hold_data", 64'(data_out), 64'(hold_data));
            end
            check("overrun", 64'(overrun), 64'(cyc >= ovr_from));
        end
    end

    // Stimulus
    initial begin
        logic [N-1:0]   v;
        logic [N*W-1:0] w;
        for (int k = 0; k < N; k++) wt[k] = 8'($urandom_range(1, 255));
        repeat (3) @(negedge clk);
        check("rst_data_out", 64'(data_out), 64'd0);
        check("rst_overrun", 64'(overrun), 64'd0);

        // all neurons at once
        step(4'hF, pack4(16'h0001, 16'h0002, 16'h0003, 16'h0004));
        idle(8);

        // staggered arrivals
        step(4'b0001, pack4(16'h1111, 16'h0, 16'h0, 16'h0));
        idle(1);
        step(4'b0010, pack4(16'h0, 16'h2222, 16'h0, 16'h0));
        idle(1);
        step(4'b0100, pack4(16'h0, 16'h0, 16'h3333, 16'h0));
        idle(1);
        step(4'b1000, pack4(16'h0, 16'h0, 16'h0, 16'h4444));
        idle(8);

        // second vector while the first streams
        step(4'hF, pack4(16'hA001, 16'hA002, 16'hA003, 16'hA004));
        idle(2);
        step(4'hF, pack4(16'hB001, 16'hB002, 16'hB003, 16'hB004));
        idle(12);

        // repeated pulse on neuron 2 before the bank drains
        step(4'b0100, pack4(16'h0, 16'h0, 16'hC0DE, 16'h0));
        step(4'b0100, pack4(16'h0, 16'h0, 16'hDEAD, 16'h0));
        step(4'b1011, pack4(16'h5001, 16'h5002, 16'h0, 16'h5004));
        idle(10);

        // reset mid-stream after word 1, then a fresh vector
        step(4'hF, pack4(16'h7001, 16'h7002, 16'h7003, 16'h7004));
        idle(3);
        do_reset();
        idle(2);
        step(4'hF, pack4(16'h9001, 16'h9002, 16'h9003, 16'h9004));
        idle(8);

        // randomised traffic, including captures coinciding with loads
        for (int t = 0; t < 300; t++) begin
            v = ($urandom_range(0, 3) == 0) ? N'($urandom_range(0, 15)) : '0;
            for (int i = 0; i < N; i++) w[i*W +: W] = W'($urandom_range(0, 65535));
            step(v, w);
        end
        idle(20);

        check("vectors_streamed", 64'(vec_seen), 64'(vec_exp));
        check("queue_drained", 64'(exp_q.size()), 64'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
